// File: rtl/masked_gf16_inverter_stream.sv
// masked_gf16_inverter_stream
//   Domain-oriented-masked (DOM) inverter over GF(2^4), built as the Canright
//   normal-basis tower GF((2^2)^2). It has a valid/ready stream interface.
//   When the output is held, the whole pipeline stalls.
//   Per share the nibble is {A[1:0], B[1:0]}. The inverse is computed as
//     E = sq(N*(A^B)^2 ^ A*B),  out = {B*E, A*E}
//   The squaring in GF(2^2) is a bit swap, so it stays linear per share.
//
// Configuration macro: OUTPUT_REFRESH_EN
//   Adds _RxDI and a third register stage that re-randomises the output
//   shares. This makes the latency 3 and RndUsexSO 3 bits wide.
//
// Ports
//   ClkxCI       clock, rising edge
//   RstxBI       asynchronous reset, active low
//   _XxDI        input shares, share i at [4i+3:4i]
//   InValidxSI   input valid
//   InReadyxSO   input ready (equals the pipeline advance)
//   _Zmul1xDI    fresh masks for E = N(A^B)^2 ^ A*B
//   _Zmul2xDI    fresh masks for A*E
//   _Zmul3xDI    fresh masks for B*E
//   _RxDI        refresh masks (only with OUTPUT_REFRESH_EN)
//   RndUsexSO    per-stage randomness-consumed strobes
//   _QxDO        output shares {B*E, A*E}
//   OutValidxSO  output valid
//   OutReadyxSI  downstream ready
//   OccxSO       number of valid items in flight
module masked_gf16_inverter_stream #(
  parameter int SHARES = 2,
  localparam int ZW = SHARES * (SHARES - 1)
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic [4*SHARES-1:0]   _XxDI,
  input  logic                  InValidxSI,
  output logic                  InReadyxSO,
  input  logic [ZW-1:0]         _Zmul1xDI,
  input  logic [ZW-1:0]         _Zmul2xDI,
  input  logic [ZW-1:0]         _Zmul3xDI,
`ifdef OUTPUT_REFRESH_EN
  input  logic [4*(SHARES-1)-1:0] _RxDI,
  output logic [2:0]            RndUsexSO,
`else
  output logic [1:0]            RndUsexSO,
`endif
  output logic [4*SHARES-1:0]   _QxDO,
  output logic                  OutValidxSO,
  input  logic                  OutReadyxSI,
  output logic [1:0]            OccxSO
);

  // GF(2^2) multiply in the normal basis {W^2, W}
  function automatic logic [1:0] gf4Mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf4Sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // N * x^2 with N = W^2
  function automatic logic [1:0] gf4SqScl(input logic [1:0] x);
    return {x[1], x[1] ^ x[0]};
  endfunction

  // Each unordered share pair (lo<hi) owns one 2-bit slice of a mask bus
  function automatic int pairIdx(input int lo, input int hi);
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic adv, accept;
  logic v1Q, v2Q;
  logic [SHARES-1:0][1:0] aD, bD, innerD;
  logic [SHARES-1:0][SHARES-1:0][1:0] crossD;
  logic [SHARES-1:0][1:0] s1AQ, s1BQ, s1InnerQ;
  logic [SHARES-1:0][SHARES-1:0][1:0] s1CrossQ;
  logic [SHARES-1:0][1:0] eShare;
  logic [SHARES-1:0][1:0] aeInnerD, beInnerD, aeInnerQ, beInnerQ;
  logic [SHARES-1:0][SHARES-1:0][1:0] aeCrossD, beCrossD, aeCrossQ, beCrossQ;
  logic [4*SHARES-1:0] qComp;

  assign adv        = ~OutValidxSO | OutReadyxSI;
  assign accept     = InValidxSI & adv;
  assign InReadyxSO = adv;

  // Stage-1 inputs: split the shares, and form the inner term
  // N(A_i^B_i)^2 ^ A_i*B_i plus the masked cross products A_i*B_j.
  // Diagonal cross entries stay zero so the compression can XOR whole rows.
  always_comb begin
    aD     = '0;
    bD     = '0;
    innerD = '0;
    crossD = '0;
    for (int i = 0; i < SHARES; i++) begin
      aD[i] = _XxDI[4*i+2 +: 2];
      bD[i] = _XxDI[4*i +: 2];
    end
    for (int i = 0; i < SHARES; i++) begin
      innerD[i] = gf4SqScl(aD[i] ^ bD[i]) ^ gf4Mul(aD[i], bD[i]);
      for (int j = 0; j < SHARES; j++) begin
        if (i < j)
          crossD[i][j] = gf4Mul(aD[i], bD[j]) ^ _Zmul1xDI[2*pairIdx(i, j) +: 2];
        else if (i > j)
          crossD[i][j] = gf4Mul(aD[i], bD[j]) ^ _Zmul1xDI[2*pairIdx(j, i) +: 2];
      end
    end
  end

  // Stage-2 inputs: compress E per domain from registered terms only.
  // Invert it by squaring, then build the DOM terms of A*E and B*E.
  always_comb begin
    eShare   = '0;
    aeInnerD = '0;
    beInnerD = '0;
    aeCrossD = '0;
    beCrossD = '0;
    for (int i = 0; i < SHARES; i++) begin
      logic [1:0] theta;
      theta = s1InnerQ[i];
      for (int j = 0; j < SHARES; j++)
        theta = theta ^ s1CrossQ[i][j];
      eShare[i] = gf4Sq(theta);
    end
    for (int i = 0; i < SHARES; i++) begin
      aeInnerD[i] = gf4Mul(s1AQ[i], eShare[i]);
      beInnerD[i] = gf4Mul(s1BQ[i], eShare[i]);
      for (int j = 0; j < SHARES; j++) begin
        if (i < j) begin
          aeCrossD[i][j] = gf4Mul(s1AQ[i], eShare[j]) ^ _Zmul2xDI[2*pairIdx(i, j) +: 2];
          beCrossD[i][j] = gf4Mul(s1BQ[i], eShare[j]) ^ _Zmul3xDI[2*pairIdx(i, j) +: 2];
        end else if (i > j) begin
          aeCrossD[i][j] = gf4Mul(s1AQ[i], eShare[j]) ^ _Zmul2xDI[2*pairIdx(j, i) +: 2];
          beCrossD[i][j] = gf4Mul(s1BQ[i], eShare[j]) ^ _Zmul3xDI[2*pairIdx(j, i) +: 2];
        end
      end
    end
  end

  // Per-domain compression of the stage-2 registers into output shares.
  // The B*E product goes in the high half of each share nibble.
  always_comb begin
    qComp = '0;
    for (int i = 0; i < SHARES; i++) begin
      logic [1:0] qa, qb;
      qa = aeInnerQ[i];
      qb = beInnerQ[i];
      for (int j = 0; j < SHARES; j++) begin
        qa = qa ^ aeCrossQ[i][j];
        qb = qb ^ beCrossQ[i][j];
      end
      qComp[4*i +: 4] = {qb, qa};
    end
  end

  // The valid flags shift only on advance. Data registers load only when
  // their stage's randomness strobe fires, so a bubble never consumes masks.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      v1Q      <= 1'b0;
      v2Q      <= 1'b0;
      s1AQ     <= '0;
      s1BQ     <= '0;
      s1InnerQ <= '0;
      s1CrossQ <= '0;
      aeInnerQ <= '0;
      beInnerQ <= '0;
      aeCrossQ <= '0;
      beCrossQ <= '0;
    end else if (adv) begin
      v1Q <= accept;
      v2Q <= v1Q;
      if (accept) begin
        s1AQ     <= aD;
        s1BQ     <= bD;
        s1InnerQ <= innerD;
        s1CrossQ <= crossD;
      end
      if (v1Q) begin
        aeInnerQ <= aeInnerD;
        beInnerQ <= beInnerD;
        aeCrossQ <= aeCrossD;
        beCrossQ <= beCrossD;
      end
    end
  end

`ifdef OUTPUT_REFRESH_EN
  logic v3Q;
  logic [4*SHARES-1:0] qRefD, qRefQ;

  // Ring refresh: R[i] is added to shares i and i+1, so it cancels in the
  // XOR of all shares. The two end shares see only one R term.
  always_comb begin
    qRefD = qComp;
    for (int i = 0; i < SHARES - 1; i++) begin
      qRefD[4*i +: 4]     = qRefD[4*i +: 4] ^ _RxDI[4*i +: 4];
      qRefD[4*(i+1) +: 4] = qRefD[4*(i+1) +: 4] ^ _RxDI[4*i +: 4];
    end
  end

  // Output refresh register. It follows the same advance/strobe rule.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      v3Q   <= 1'b0;
      qRefQ <= '0;
    end else if (adv) begin
      v3Q <= v2Q;
      if (v2Q)
        qRefQ <= qRefD;
    end
  end

  assign OutValidxSO = v3Q;
  assign _QxDO       = qRefQ;
  assign RndUsexSO   = {adv & v2Q, adv & v1Q, accept};
  assign OccxSO      = {1'b0, v1Q} + {1'b0, v2Q} + {1'b0, v3Q};
`else
  assign OutValidxSO = v2Q;
  assign _QxDO       = qComp;
  assign RndUsexSO   = {adv & v1Q, accept};
  assign OccxSO      = {1'b0, v1Q} + {1'b0, v2Q};
`endif

endmodule

// File: tb/tb_masked_gf16_inverter_stream.sv
// tb_masked_gf16_inverter_stream
//   Directed bench for masked_gf16_inverter_stream with SHARES=2.
//   Expected inverses come from a hand-computed table for the Canright
//   normal basis (one = 0xF). A product check x*inv(x) = 0xF backs up the table.
module tb_masked_gf16_inverter_stream;

  localparam int SHARES = 2;
  localparam int ZW = SHARES * (SHARES - 1);
`ifdef OUTPUT_REFRESH_EN
  localparam int LAT = 3;
  localparam int RW = 3;
`else
  localparam int LAT = 2;
  localparam int RW = 2;
`endif

  logic clock = 1'b0;
  logic resetN;
  logic [4*SHARES-1:0] xShares;
  logic inValid, inReady;
  logic [ZW-1:0] zMul1, zMul2, zMul3;
  logic [RW-1:0] rndUse;
  logic [4*SHARES-1:0] qShares;
  logic outValid, outReady;
  logic [1:0] occ;
`ifdef OUTPUT_REFRESH_EN
  logic [4*(SHARES-1)-1:0] rShares;
`endif

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  logic [3:0] expX[$];

  // inverse table worked out by hand in the normal basis
  logic [3:0] invTable [16] = '{4'h0, 4'hC, 4'h8, 4'h4, 4'h3, 4'hA, 4'h7, 4'h6,
                                4'h2, 4'hD, 4'h5, 4'hE, 4'h1, 4'h9, 4'hB, 4'hF};
  logic [3:0] stallItems [4] = '{4'h2, 4'h9, 4'h6, 4'hD};

  masked_gf16_inverter_stream #(.SHARES(SHARES)) dut (
    .ClkxCI      (clock),
    .RstxBI      (resetN),
    ._XxDI       (xShares),
    .InValidxSI  (inValid),
    .InReadyxSO  (inReady),
    ._Zmul1xDI   (zMul1),
    ._Zmul2xDI   (zMul2),
    ._Zmul3xDI   (zMul3),
`ifdef OUTPUT_REFRESH_EN
    ._RxDI       (rShares),
`endif
    .RndUsexSO   (rndUse),
    ._QxDO       (qShares),
    .OutValidxSO (outValid),
    .OutReadyxSI (outReady),
    .OccxSO      (occ)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [1:0] gf4Mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [3:0] gf16Mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = gf4Mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
    e = {e[0], e[1] ^ e[0]};
    return {gf4Mul(x[3:2], y[3:2]) ^ e, gf4Mul(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic logic [3:0] xorShares(input logic [4*SHARES-1:0] q);
    logic [3:0] acc;
    acc = '0;
    for (int i = 0; i < SHARES; i++) acc = acc ^ q[4*i +: 4];
    return acc;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic freshRandom();
    zMul1 = ZW'($urandom);
    zMul2 = ZW'($urandom);
    zMul3 = ZW'($urandom);
`ifdef OUTPUT_REFRESH_EN
    rShares = (4*(SHARES-1))'($urandom);
`endif
  endtask

  // random sharing of x plus fresh masks for every stage
  task automatic applyStimulus(input logic valid, input logic [3:0] x);
    logic [3:0] acc, s;
    acc = x;
    for (int i = 1; i < SHARES; i++) begin
      s = 4'($urandom_range(0, 15));
      xShares[4*i +: 4] = s;
      acc = acc ^ s;
    end
    xShares[3:0] = acc;
    inValid = valid;
    freshRandom();
  endtask

  task automatic observeOutput(input string tag);
    logic [3:0] xIn, qx;
    if (expX.size() == 0) begin
      checkOutput({tag, "_spurious"}, outValid, 1'b0);
    end else if (outValid) begin
      xIn = expX.pop_front();
      qx  = xorShares(qShares);
      checkOutput({tag, "_inv"}, qx, invTable[xIn]);
      if (xIn != 4'h0) checkOutput({tag, "_unity"}, gf16Mul(xIn, qx), 4'hF);
      outCount++;
    end
  endtask

  initial begin
    int accepted;
    logic [4*SHARES-1:0] holdQ;
    logic acceptHist [16];
    logic v, expRnd1, expOv;

    // ---------------- reset state ----------------
    resetN = 1'b0; inValid = 1'b0; outReady = 1'b1; xShares = '0;
    freshRandom();
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_outValid", outValid, 1'b0);
    checkOutput("rst_occ", occ, 2'd0);
    checkOutput("rst_q", qShares, '0);
    checkOutput("rst_rndUse", rndUse, '0);
    checkOutput("rst_inReady", inReady, 1'b1);
    outReady = 1'b0;
    #1 checkOutput("rst_inReady_noOut", inReady, 1'b1);
    outReady = 1'b1;
    @(negedge clock);
    resetN = 1'b1;

    // ---------------- zero input, shares 0x3/0x3 ----------------
    @(negedge clock);
    xShares = 8'h33; inValid = 1'b1; freshRandom();
    #1;
    checkOutput("zero_rnd_accept", rndUse, 1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      inValid = 1'b0; freshRandom();
      #1;
      if (k == 1) begin
        checkOutput("zero_occ_s1", occ, 2'd1);
        checkOutput("zero_rnd_s1", rndUse, 2);
      end
      if (k < LAT) checkOutput("zero_early", outValid, 1'b0);
      else begin
        checkOutput("zero_valid", outValid, 1'b1);
        checkOutput("zero_value", xorShares(qShares), 4'h0);
      end
    end
    @(negedge clock);
    #1;
    checkOutput("zero_gone", outValid, 1'b0);
    checkOutput("zero_occ_empty", occ, 2'd0);

    // ---------------- sweep of all 16 inputs, streaming ----------------
    outCount = 0;
    for (int k = 0; k < 16 + LAT + 2; k++) begin
      @(negedge clock);
      observeOutput("sweep");
      if (k < 16) begin
        applyStimulus(1'b1, 4'(k));
        expX.push_back(4'(k));
      end else applyStimulus(1'b0, 4'h0);
    end
    checkOutput("sweep_count", outCount, 16);

    // ---------------- stall with back-to-back accepts ----------------
    outReady = 1'b0; outCount = 0; accepted = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      #1;
      if (!inReady || accepted >= 4) break;
      applyStimulus(1'b1, stallItems[accepted]);
      expX.push_back(stallItems[accepted]);
      accepted++;
    end
    checkOutput("stall_accepted", accepted, LAT);
    applyStimulus(1'b1, 4'h7);
    #1;
    holdQ = qShares;
    checkOutput("stall_inReady", inReady, 1'b0);
    checkOutput("stall_occ", occ, LAT);
    checkOutput("stall_rndUse", rndUse, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      applyStimulus(1'b1, 4'($urandom_range(0, 15)));
      #1;
      checkOutput("hold_q", qShares, holdQ);
      checkOutput("hold_occ", occ, LAT);
      checkOutput("hold_inReady", inReady, 1'b0);
      checkOutput("hold_rndUse", rndUse, '0);
      checkOutput("hold_outValid", outValid, 1'b1);
    end
    @(negedge clock);
    inValid = 1'b0; outReady = 1'b1; freshRandom();
    #1;
    checkOutput("release_rnd1", rndUse[1], 1'b1);
    for (int k = 0; k < LAT + 3; k++) begin
      observeOutput("drain");
      @(negedge clock);
      freshRandom();
      #1;
    end
    checkOutput("drain_count", outCount, LAT);

    // ---------------- alternating valid, bubbles ----------------
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      expOv = 1'b0;
      if (k >= LAT) expOv = acceptHist[k-LAT];
      checkOutput("alt_outValid", outValid, expOv);
      observeOutput("alt");
      v = (k % 2 == 0) && (k < 8);
      applyStimulus(v, 4'(k + 3));
      if (v) expX.push_back(4'(k + 3));
      acceptHist[k] = v;
      #1;
      expRnd1 = 1'b0;
      if (k >= 1) expRnd1 = acceptHist[k-1];
      checkOutput("alt_rnd0", rndUse[0], v);
      checkOutput("alt_rnd1", rndUse[1], expRnd1);
    end

    // ---------------- asynchronous reset mid-operation ----------------
    @(negedge clock);
    applyStimulus(1'b1, 4'hA);
    @(negedge clock);
    applyStimulus(1'b1, 4'hC);
    @(negedge clock);
    applyStimulus(1'b0, 4'h0);
    #1;
    checkOutput("preRst_occ", occ, 2'd2);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midRst_outValid", outValid, 1'b0);
    checkOutput("midRst_occ", occ, 2'd0);
    checkOutput("midRst_q", qShares, '0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    applyStimulus(1'b1, 4'hB);
    expX.push_back(4'hB);
    outCount = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clock);
      applyStimulus(1'b0, 4'h0);
      #1;
      checkOutput("postRst_outValid", outValid, (k == LAT));
      if (k == LAT) observeOutput("postRst");
    end
    checkOutput("postRst_count", outCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
